// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment scanner: polarity,
// blank/hex segment patterns and counter width sizing.
package display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high gfedcba patterns for hex digits 0-F.
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic pol(input logic v, input bit act_low);
    return v ^ act_low;
  endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Logic-side bundle of the scanner: shadowed display inputs, live blank,
// and the registered pin-level outputs.
interface display_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 7,
  parameter int BRIGHT_W   = 3
);
  logic [NUM_DIGITS*SEG_W-1:0] digit_data;
  logic [NUM_DIGITS-1:0]       digit_en;
  logic [BRIGHT_W-1:0]         brightness;
  logic                        blank;
  logic [SEG_W-1:0]            seg;
  logic [NUM_DIGITS-1:0]       anode;
  logic                        frame_tick;

  modport master (output digit_data, digit_en, brightness, blank,
                  input  seg, anode, frame_tick);
  modport slave  (input  digit_data, digit_en, brightness, blank,
                  output seg, anode, frame_tick);
endinterface

// File: rtl/display_scanner_scan_timer.sv
// Slot/digit sequencer: slot_cnt runs 0..SCAN_DIV-1, idx steps on each wrap,
// frame_edge flags the idx N-1 -> 0 edge and frame_tick is its registered pulse.
module scan_timer
  import display_pkg::*;
#(
  parameter  int SCAN_DIV   = 250000,
  parameter  int NUM_DIGITS = 4,
  localparam int SLOT_W     = cnt_w(SCAN_DIV),
  localparam int IDX_W      = cnt_w(NUM_DIGITS)
) (
  input  logic              Clock,
  input  logic              Resetn,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic [IDX_W-1:0]  idx,
  output logic              frame_edge,
  output logic              frame_tick
);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic slot_wrap;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_edge = slot_wrap && (idx == IDX_LAST);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      slot_cnt   <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_edge;
      if (slot_wrap) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed N-digit seven-segment driver with dead time, PWM dimming
// and frame-synchronous shadow loading of the display inputs.
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SEG_W       = 7,
  parameter int SCAN_DIV    = 250000,
  parameter int DEAD_CYC    = 2,
  parameter int BRIGHT_W    = 3,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input logic              Clock,
  input logic              Resetn,
  display_scanner_if.slave bus
);

  localparam int SLOT_W = cnt_w(SCAN_DIV);
  localparam int IDX_W  = cnt_w(NUM_DIGITS);
  localparam logic [SLOT_W-1:0]     DEAD_V  = SLOT_W'(DEAD_CYC);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? '1 : '0;
  localparam logic [SEG_W-1:0]      SEG_OFF = (SEG_ACT_LOW != 0) ? '1 : '0;

  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  idx;
  logic              frame_edge;
  logic              frame_tick_q;

  scan_timer #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(NUM_DIGITS)) u_timer (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .slot_cnt   (slot_cnt),
    .idx        (idx),
    .frame_edge (frame_edge),
    .frame_tick (frame_tick_q)
  );

  logic [NUM_DIGITS-1:0][SEG_W-1:0] data_sh;
  logic [NUM_DIGITS-1:0]            en_sh;
  logic [BRIGHT_W-1:0]              bright_sh;
  logic [BRIGHT_W-1:0]              pwm_cnt;
  logic [NUM_DIGITS-1:0]            anode_q, an_d;
  logic [SEG_W-1:0]                 seg_q, seg_d, seg_lit;
  logic                             on;

  // Blank is deliberately live; everything else is seen only through shadows.
  always_comb begin
    on      = en_sh[idx] && (slot_cnt >= DEAD_V) && (pwm_cnt <= bright_sh) && !bus.blank;
    seg_lit = on ? data_sh[idx] : SEG_BLANK[SEG_W-1:0];
    an_d    = '0;
    seg_d   = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      an_d[i] = pol(on && (idx == IDX_W'(i)), AN_ACT_LOW != 0);
    for (int b = 0; b < SEG_W; b++)
      seg_d[b] = pol(seg_lit[b], SEG_ACT_LOW != 0);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      data_sh   <= '0;
      en_sh     <= '0;
      bright_sh <= '0;
      pwm_cnt   <= '0;
      anode_q   <= AN_OFF;
      seg_q     <= SEG_OFF;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      anode_q <= an_d;
      seg_q   <= seg_d;
      if (frame_edge) begin
        data_sh   <= bus.digit_data;
        en_sh     <= bus.digit_en;
        bright_sh <= bus.brightness;
      end
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: cycle scoreboard from a time-indexed model,
// table of brightness/enable frames, plus shadow, blank and reset sequences.
module tb_display_scanner;
  import display_pkg::*;

  logic Clock;
  logic Resetn;

  display_scanner_if #(.NUM_DIGITS(4), .SEG_W(7), .BRIGHT_W(2)) bus ();

  display_scanner #(
    .NUM_DIGITS(4), .SEG_W(7), .SCAN_DIV(8), .DEAD_CYC(2),
    .BRIGHT_W(2), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  typedef struct {
    logic [27:0] data;
    logic [3:0]  en;
    logic [1:0]  br;
    int          exp_lit;
  } vec_t;

  int   checks, fails;
  exp_t sb[$];
  int   mt;
  logic [3:0][6:0] m_data;
  logic [3:0]      m_en;
  logic [1:0]      m_br;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mt = 0; m_data = '0; m_en = '0; m_br = '0;
  endtask

  // Expected output for the next cycle is derived from elapsed time since release.
  task automatic step();
    exp_t e, g;
    int slot, ix, pwm;
    logic on;
    @(posedge Clock);
    if (!Resetn) begin
      e = '{an: 4'hF, seg: 7'h7F, ft: 1'b0};
    end else begin
      slot = mt % 8; ix = (mt / 8) % 4; pwm = mt % 4;
      on = m_en[ix] && (slot >= 2) && (pwm <= int'(m_br)) && !bus.blank;
      e.an  = on ? ~(4'b0001 << ix) : 4'hF;
      e.seg = on ? ~m_data[ix] : 7'h7F;
      e.ft  = (mt % 32 == 31);
      if (mt % 32 == 31) begin
        m_data = bus.digit_data; m_en = bus.digit_en; m_br = bus.brightness;
      end
      mt++;
    end
    sb.push_back(e);
    @(negedge Clock);
    g = sb.pop_front();
    chk("anode", 32'(bus.anode), 32'(g.an));
    chk("seg", 32'(bus.seg), 32'(g.seg));
    chk("frame_tick", 32'(bus.frame_tick), 32'(g.ft));
    chk("anode_exclusive", 32'($countones(~bus.anode) <= 1), 32'd1);
    if (bus.anode == 4'hF) chk("seg_dark_when_no_anode", 32'(bus.seg), 32'h7F);
  endtask

  task automatic wait_ft();
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.frame_tick) return;
    end
    checks++; fails++;
    $display("FAIL wait_frame_tick timed out at %0t", $time);
  endtask

  task automatic wait_lit();
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.anode != 4'hF) return;
    end
    checks++; fails++;
    $display("FAIL wait_lit timed out at %0t", $time);
  endtask

  task automatic measure_frame(input string name, input int exp_lit);
    int lit, ft_at;
    lit = 0; ft_at = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (bus.anode != 4'hF) lit++;
      if (bus.frame_tick && ft_at == 0) ft_at = k;
    end
    chk({name, "_lit_cycles"}, 32'(lit), 32'(exp_lit));
    chk({name, "_tick_cycle"}, 32'(ft_at), 32'd32);
  endtask

  task automatic apply(input vec_t v);
    bus.digit_data = v.data; bus.digit_en = v.en; bus.brightness = v.br;
  endtask

  initial begin
    logic [6:0] d0_old, d0_new, want;
    vecs[0] = '{data: {7'h06, 7'h5B, 7'h4F, 7'h66}, en: 4'hF, br: 2'd3, exp_lit: 24};
    vecs[1] = '{data: {7'h06, 7'h5B, 7'h4F, 7'h66}, en: 4'hF, br: 2'd0, exp_lit: 4};
    vecs[2] = '{data: {7'h06, 7'h5B, 7'h4F, 7'h66}, en: 4'hF, br: 2'd1, exp_lit: 8};
    vecs[3] = '{data: {7'h06, 7'h5B, 7'h4F, 7'h66}, en: 4'hF, br: 2'd2, exp_lit: 16};
    vecs[4] = '{data: {7'h06, 7'h5B, 7'h4F, 7'h66}, en: 4'b0101, br: 2'd3, exp_lit: 12};
    vecs[5] = '{data: {HEX7[12], HEX7[0], HEX7[13], HEX7[14]}, en: 4'b1000, br: 2'd3, exp_lit: 6};

    checks = 0; fails = 0;
    model_reset();
    Resetn = 1'b1; bus.blank = 1'b0;
    apply(vecs[0]);

    // Power-on reset: outputs inactive without waiting for a clock edge.
    #1 Resetn = 1'b0;
    #1;
    chk("reset_anode", 32'(bus.anode), 32'hF);
    chk("reset_seg", 32'(bus.seg), 32'h7F);
    chk("reset_frame_tick", 32'(bus.frame_tick), 32'd0);
    repeat (2) step();
    Resetn = 1'b1;
    measure_frame("first_frame", 0);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      wait_ft();
      measure_frame($sformatf("vec%0d", i), vecs[i].exp_lit);
    end

    // Shadow: a mid-slot change of digit 0 must wait for the next frame.
    apply(vecs[0]);
    d0_old = vecs[0].data[6:0];
    d0_new = HEX7[8];
    wait_ft();
    repeat (3) step();
    want = ~d0_old;
    chk("shadow_before_change", 32'(bus.seg), 32'(want));
    bus.digit_data[6:0] = d0_new;
    step();
    chk("shadow_held_midframe", 32'(bus.seg), 32'(want));
    wait_ft();
    repeat (3) step();
    want = ~d0_new;
    chk("shadow_new_anode", 32'(bus.anode), 32'hE);
    chk("shadow_new_seg", 32'(bus.seg), 32'(want));

    // Live blank for 3 cycles inside a lit slot.
    wait_lit();
    bus.blank = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        step();
        bus.blank = 1'b0;
      end else begin
        step();
      end
      chk($sformatf("blank_anode_%0d", k), 32'(bus.anode), 32'hF);
      chk($sformatf("blank_seg_%0d", k), 32'(bus.seg), 32'h7F);
    end
    repeat (4) step();

    // Reset in the middle of a lit slot.
    wait_lit();
    #2 Resetn = 1'b0;
    #1;
    chk("midreset_anode", 32'(bus.anode), 32'hF);
    chk("midreset_seg", 32'(bus.seg), 32'h7F);
    chk("midreset_frame_tick", 32'(bus.frame_tick), 32'd0);
    model_reset();
    repeat (2) step();
    Resetn = 1'b1;
    measure_frame("post_reset_frame", 0);
    measure_frame("post_reset_second", 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
# display_scanner

Parametrised time-multiplexed driver for an N-digit common-anode/cathode seven-segment display. It replaces the fixed four-digit selector, adding:
- a per-digit segment bus and per-digit enables;
- anode outputs and an inter-digit dead time against ghosting;
- PWM brightness control;
- frame-synchronous shadow loading, so a display update never tears mid-scan.

It sits between game/score logic and the board's segment/anode pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=1)
- SEG_W, 7, segment lines per digit (8 when a decimal point is used)
- SCAN_DIV, 250000, clock cycles per digit slot (>= DEAD_CYC+2)
- DEAD_CYC, 2, cycles at the start of every slot with all anodes off
- BRIGHT_W, 3, brightness code width
- SEG_ACT_LOW, 1, 1 = segment pins lit at 0
- AN_ACT_LOW, 1, 1 = anode pins active at 0

Ports:
- Clock  in  1  system clock, rising edge
- Resetn  in  1  asynchronous, active-low reset
- digit_data  in  NUM_DIGITS*SEG_W  segment patterns, active-high (1 = lit); digit i at [i*SEG_W +: SEG_W]
- digit_en  in  NUM_DIGITS  per-digit enable
- brightness  in  BRIGHT_W  0 = dimmest, all-ones = full on
- blank  in  1  live global blank, not shadowed
- seg  out  SEG_W  segment pins, polarity per SEG_ACT_LOW
- anode  out  NUM_DIGITS  anode pins, polarity per AN_ACT_LOW
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
- slot_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap, idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
  - A slot is exactly SCAN_DIV cycles; a frame is NUM_DIGITS*SCAN_DIV cycles.
- Frame boundary is the edge where idx goes NUM_DIGITS-1 -> 0. On that same edge:
  - digit_data, digit_en and brightness are captured into shadow registers;
  - frame_tick is high for exactly that one cycle.
  - Input changes at any other time have no visible effect until the next boundary.
- pwm_cnt (BRIGHT_W bits) free-runs from reset, +1 every cycle, and wraps.
- Digit "on" condition: idx==i AND en_sh[i] AND slot_cnt>=DEAD_CYC AND pwm_cnt<=bright_sh AND !blank.
  - Duty = (bright_sh+1)/2^BRIGHT_W. With all-ones brightness there is no PWM gap.
- A disabled digit keeps its slot but stays dark. Frame period never changes.
- Output encoding:
  - anode[i] is active when the digit is on.
  - seg is data_sh[idx] when the digit is on, otherwise all-unlit.
  - Polarity is applied last.
- Invariants: at most one anode is active in any cycle. seg is never lit while no anode is active.

## Timing
- All outputs are registered. They reflect the counter/shadow/blank state of the previous cycle, i.e. 1-cycle latency.
- blank asserted in cycle t means anode and seg are off from cycle t+1. This holds even mid-slot.
- Reset, asynchronous, takes effect immediately:
  - slot_cnt, idx, pwm_cnt = 0
  - all shadow registers = 0
  - anode = all inactive
  - seg = all unlit
  - frame_tick = 0
- After reset release, the first frame is dark because en_sh = 0. The first shadow load happens NUM_DIGITS*SCAN_DIV cycles after release.
- Reset asserted mid-slot forces outputs inactive in the same cycle, with no glitch to a lit state.
- Counter widths: $clog2(SCAN_DIV) and $clog2(NUM_DIGITS), each with a minimum of 1. Comparisons are unsigned.

## Structure
- Shared package display_pkg holds:
  - the polarity helper;
  - SEG_BLANK and the hex-to-7-seg constant table (0-F, active-high);
  - the width helper.
- Sub-module scan_timer (slot_cnt, idx, frame_tick; parameters SCAN_DIV, NUM_DIGITS) is natural. The top adds the shadow registers, PWM and output encoding.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYC=2, BRIGHT_W=2, both polarities active-low.
- Scan order: digit_data={7'h06,7'h5B,7'h4F,7'h66}, all enabled, brightness=3.
  - frame_tick every 32 cycles.
  - anode cycles 1110 -> 1101 -> 1011 -> 0111; each active for 6 of every 8 cycles.
  - seg = ~pattern while its anode is active.
- Dead time / exclusivity: every cycle, at most one anode bit is 0. seg=7'h7F whenever anode=4'hF. The first 2 cycles of each slot are dark.
- PWM: brightness=0 -> active anode low 1 cycle in 4 (after dead time); brightness=1 -> 2 in 4; brightness=3 -> continuous.
- Shadow: change digit_data[0] mid-frame -> seg is unchanged until after the next frame_tick; next frame shows the new value.
- Enable/blank:
  - digit_en=4'b0101 -> slots 1 and 3 dark; frame period still 32.
  - blank pulse of 3 cycles -> outputs dark for cycles t+1..t+3.
- Reset: assert Resetn=0 mid-slot -> anode=4'hF, seg=7'h7F, frame_tick=0 immediately. After release, the first 32 cycles are dark and the first frame_tick is at cycle 32.
